vec4_serializer: RTL and testbench
==================================

# vec4_serializer

Streams a packed vector of four 32-bit IEEE-754 single-precision words out one word per cycle. It feeds the pipelined `float_add` reduction blocks, which consume one float per enabled clock. It sits between vector producers (transform/projection stages) and the scalar float pipelines. It supplies per-word framing (first/last/index) and valid/ready backpressure so a downstream accumulator can align its group-of-four boundaries.

## Interface
Parameters:
- `WIDTH`, 32: bits per word.
- `LANES`, 4: words per vector. Fixed at 4; index width is 2.

Ports:
- `clock`  in  1  rising-edge clock.
- `aclr_n`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `clk_en`  in  1  clock enable. When low, no state changes and no handshake completes.
- `in_valid`  in  1  `in_data` holds a vector.
- `in_ready`  out  1  block accepts a vector this cycle (combinational).
- `in_data`  in  WIDTH*LANES  lane k at bits [32k+31:32k].
- `out_valid`  out  1  `out_data` holds a word (registered).
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  WIDTH  current lane word.
- `out_index`  out  2  lane number of `out_data`.
- `out_first`  out  1  high when `out_index`==0 and `out_valid`.
- `out_last`  out  1  high when `out_index`==3 and `out_valid`.

## Operation
- Input transfer: `in_valid & in_ready & clk_en` at a rising edge. Output transfer: `out_valid & out_ready & clk_en`.
- State is a holding register `hold[127:0]`, a lane counter `idx[1:0]` and a state bit with two states:
  - IDLE: `out_valid`=0.
  - SEND: `out_valid`=1.
- IDLE:
  - `in_ready`=1.
  - On input transfer: `hold`<=`in_data`, `idx`<=0, go to SEND.
- SEND, `out_data` = `hold[32*idx +: 32]`.
  - Output transfer with `idx`<3: `idx`<=`idx`+1.
  - Output transfer with `idx`==3: if an input transfer occurs the same edge, reload `hold`, `idx`<=0 and stay in SEND. Otherwise go to IDLE.
- `in_ready` = `aclr_n` & (IDLE | (SEND & `idx`==3 & `out_ready`)). No combinational path from `in_valid` to `out_*`.
- Lane order is always 0,1,2,3. Words pass bit-exact; no arithmetic is performed on the data.
- `out_valid` stalled by `out_ready`=0: `out_data`, `out_index`, `out_first` and `out_last` stay stable until the transfer.
- `in_data` is sampled only on an input transfer; later changes on `in_data` are ignored.
- `clk_en`=0: all registers hold. `in_ready` may still be 1, but no transfer counts. Outputs keep their values.
- Reset while `aclr_n`=0: all registers clear immediately, independent of `clock`. State=IDLE, `idx`=0, `hold`=0, `out_valid`=0, `out_data`=0, `out_index`=0, `out_first`=0, `out_last`=0, `in_ready`=0.
- Reset mid-vector: remaining lanes are discarded and no partial tail is emitted. After release, the next accepted vector starts at lane 0.

## Timing
- Latency: input transfer at edge N gives lane 0 on `out_data` with `out_valid`=1 after edge N (cycle N+1).
- Throughput: one word per enabled cycle with `out_ready`=1.
- Back-to-back vectors give continuous `out_valid`, so 4 words per 4 cycles with no bubble. The next vector is accepted on the edge that transfers lane 3.
- Single vector with `out_ready` held 1: `out_valid` is high for exactly 4 enabled cycles, `out_last` in the 4th, then 0.
- Reset release: the first input transfer is possible at the first rising edge with `aclr_n`=1 and `clk_en`=1.

## Test plan
- **Reset values.** Assert `aclr_n`=0 asynchronously mid-cycle → all outputs 0 and `in_ready`=0 without a clock edge. Release → `in_ready`=1.
- **Single vector.** `in_data`={0x40800000,0x40400000,0x40000000,0x3F800000} (lanes 3..0), `out_ready`=1 → 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on the 4 cycles after acceptance. `out_index` 0..3, `out_first` on cycle 1 only, `out_last` on cycle 4 only, then `out_valid`=0.
- **Back-to-back.** Two vectors, `in_valid` held high, `out_ready`=1 → 8 consecutive valid words, no gap. Second vector accepted on the edge with `idx`==3. `in_ready`=0 during lanes 0-2.
- **Backpressure.** `out_ready`=0 for 3 cycles during lane 1 → `out_data`, `out_index`=1 and `out_valid` held stable. Lane 2 follows one cycle after `out_ready` returns to 1. No word lost or duplicated.
- **Clock enable.** `clk_en`=0 for 5 cycles mid-vector with `in_valid`=1 and `out_ready`=1 → no index advance and no acceptance. Sequence resumes exactly where it stopped.
- **Reset mid-vector.** Pulse `aclr_n` low after lane 1 → `out_valid`=0 immediately. The next vector emits from its own lane 0 and no old lanes appear.

Source files
------------

// File: rtl/vec4_serializer.sv
// Serializes one 4-lane vector of 32-bit words into one word per enabled cycle, lane 0 first.
// Latency: lane 0 appears the cycle after the vector is accepted; one word per cycle after that.
// Backpressure: out_ready low freezes the current word; a new vector is accepted only in IDLE or as lane 3 leaves.
module vec4_serializer #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
) (
    input  logic                   clock,
    input  logic                   aclr_n,
    input  logic                   clk_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH*LANES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [1:0]             out_index,
    output logic                   out_first,
    output logic                   out_last
);
    localparam logic [1:0] LAST_IDX = 2'(LANES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state, state_nxt;
    logic [WIDTH*LANES-1:0] hold, hold_nxt;
    logic [1:0]             idx, idx_nxt;
    logic                   in_xfer, out_xfer;

    // Reload is only offered while the final lane is leaving, so no vector is ever overwritten early.
    assign in_ready  = aclr_n & ((state == IDLE) |
                                 ((state == SEND) & (idx == LAST_IDX) & out_ready));
    assign in_xfer   = in_valid & in_ready & clk_en;
    assign out_xfer  = out_valid & out_ready & clk_en;

    assign out_valid = (state == SEND);
    assign out_data  = hold[WIDTH*idx +: WIDTH];
    assign out_index = idx;
    assign out_first = out_valid & (idx == 2'd0);
    assign out_last  = out_valid & (idx == LAST_IDX);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    hold_nxt  = in_data;
                    idx_nxt   = 2'd0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_xfer) begin
                    if (idx != LAST_IDX) begin
                        idx_nxt = idx + 2'd1;
                    end else if (in_xfer) begin
                        hold_nxt = in_data;
                        idx_nxt  = 2'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= IDLE;
            hold  <= '0;
            idx   <= 2'd0;
        end else if (clk_en) begin
            state <= state_nxt;
            hold  <= hold_nxt;
            idx   <= idx_nxt;
        end
    end
endmodule

// File: tb/tb_vec4_serializer.sv
// Randomized self-checking bench for vec4_serializer using a word-queue reference model.
module tb_vec4_serializer;
    logic         clock, aclr_n, clk_en, in_valid, out_ready;
    logic         in_ready, out_valid, out_first, out_last;
    logic [127:0] in_data;
    logic [31:0]  out_data;
    logic [1:0]   out_index;

    int checks = 0;
    int errors = 0;

    // Model: queue of words still owed downstream; head is the word on the output.
    logic [31:0] q[$];

    logic [37:0] obs;
    assign obs = {in_ready, out_valid, out_valid ? out_index : 2'd0, out_first, out_last,
                  out_valid ? out_data : 32'h0};

    vec4_serializer #(.WIDTH(32), .LANES(4)) dut (
        .clock(clock), .aclr_n(aclr_n), .clk_en(clk_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_first(out_first), .out_last(out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [37:0] exp_obs();
        int          n;
        logic        v, r;
        logic [1:0]  ix;
        logic [31:0] w;
        n  = q.size();
        v  = (n > 0);
        r  = aclr_n && (n == 0 || (n == 1 && out_ready));
        ix = v ? 2'(4 - n) : 2'd0;
        w  = v ? q[0] : 32'h0;
        return {r, v, ix, v && (n == 4), v && (n == 1), w};
    endfunction

    function automatic logic [127:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance one clock edge and update the model from the inputs present before it.
    task automatic tick();
        logic         snd, acc;
        logic [127:0] d;
        int           n;
        n   = q.size();
        snd = aclr_n && clk_en && (n > 0) && out_ready;
        acc = aclr_n && clk_en && in_valid && (n == 0 || (n == 1 && out_ready));
        d   = in_data;
        @(posedge clock);
        if (snd) void'(q.pop_front());
        if (acc) for (int k = 0; k < 4; k++) q.push_back(d[32*k +: 32]);
        if (!aclr_n) q.delete();
        #1;
    endtask

    task automatic test_reset();
        aclr_n = 1'b1; clk_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = rand_vec();
        #2 aclr_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_index, out_first, out_last, in_ready} !== 38'h0) begin
            errors++;
            $display("FAIL reset_async got v=%b d=%h i=%0d f=%b l=%b rdy=%b want all 0",
                     out_valid, out_data, out_index, out_first, out_last, in_ready);
        end
        q.delete();
        tick(); tick();
        aclr_n = 1'b1;
        #2;
        checks++;
        if (obs !== exp_obs()) begin
            errors++; $display("FAIL reset_release got %h want %h", obs, exp_obs());
        end
        tick();
    endtask

    task automatic test_single();
        logic [31:0] sw[4];
        sw = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        in_data = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        in_valid = 1'b1; out_ready = 1'b1; clk_en = 1'b1;
        #2;
        checks++;
        if (obs !== exp_obs()) begin
            errors++; $display("FAIL single_accept got %h want %h", obs, exp_obs());
        end
        tick();
        in_valid = 1'b0; in_data = rand_vec();
        for (int c = 1; c <= 5; c++) begin
            #2;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL single cyc%0d got %h want %h", c, obs, exp_obs());
            end
            checks++;
            if (c <= 4 && (out_valid !== 1'b1 || out_data !== sw[c-1] || out_index !== 2'(c-1))) begin
                errors++;
                $display("FAIL single_word cyc%0d got v=%b d=%h i=%0d want v=1 d=%h i=%0d",
                         c, out_valid, out_data, out_index, sw[c-1], c - 1);
            end else if (c == 5 && out_valid !== 1'b0) begin
                errors++; $display("FAIL single_end got out_valid=%b want 0", out_valid);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] v1;
        logic         will_acc;
        int           acc_cnt, vld_cnt;
        acc_cnt = 0; vld_cnt = 0;
        v1 = rand_vec();
        in_data = rand_vec(); in_valid = 1'b1; out_ready = 1'b1; clk_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #2;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL b2b cyc%0d got %h want %h", c, obs, exp_obs());
            end
            if (out_valid) vld_cnt++;
            will_acc = in_valid && exp_obs()[37];
            tick();
            if (will_acc) begin
                acc_cnt++;
                if (acc_cnt == 1) in_data = v1;
                else begin in_valid = 1'b0; in_data = rand_vec(); end
            end
        end
        checks++;
        if (vld_cnt != 8 || acc_cnt != 2) begin
            errors++; $display("FAIL b2b_count got valid=%0d acc=%0d want 8 and 2", vld_cnt, acc_cnt);
        end
    endtask

    task automatic test_backpressure();
        in_data = rand_vec(); in_valid = 1'b1; out_ready = 1'b1; clk_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            out_ready = !(c >= 2 && c <= 4);
            #2;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL bp cyc%0d got %h want %h", c, obs, exp_obs());
            end
            if (c == 6) begin
                checks++;
                if (out_index !== 2'd2 || out_valid !== 1'b1) begin
                    errors++; $display("FAIL bp_lane2 got idx=%0d v=%b want 2 1", out_index, out_valid);
                end
            end
            tick();
            in_valid = 1'b0; in_data = rand_vec();
        end
    endtask

    task automatic test_clk_en();
        in_data = rand_vec(); in_valid = 1'b1; out_ready = 1'b1; clk_en = 1'b1;
        for (int c = 0; c < 16; c++) begin
            clk_en   = !(c >= 2 && c <= 6);
            in_valid = (c == 0) || (c >= 2 && c <= 8);
            #2;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL clken cyc%0d got %h want %h", c, obs, exp_obs());
            end
            tick();
            if (c >= 2 && c <= 6) in_data = rand_vec();
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] vb;
        in_data = rand_vec(); in_valid = 1'b1; out_ready = 1'b1; clk_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2 aclr_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_index, out_first, out_last, in_ready} !== 38'h0) begin
            errors++; $display("FAIL rstmid_async got v=%b d=%h i=%0d rdy=%b want all 0",
                               out_valid, out_data, out_index, in_ready);
        end
        q.delete();
        tick();
        aclr_n = 1'b1;
        vb = rand_vec(); in_data = vb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = rand_vec();
        #2;
        checks++;
        if (out_valid !== 1'b1 || out_index !== 2'd0 || out_data !== vb[31:0]) begin
            errors++; $display("FAIL rstmid_lane0 got v=%b i=%0d d=%h want 1 0 %h",
                               out_valid, out_index, out_data, vb[31:0]);
        end
        for (int c = 0; c < 5; c++) begin
            if (c > 0) #2;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL rstmid cyc%0d got %h want %h", c, obs, exp_obs());
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clk_en    = ($urandom_range(0, 5) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = rand_vec();
            #2;
            checks++;
            if (obs !== exp_obs()) begin
                errors++; $display("FAIL random cyc%0d got %h want %h", c, obs, exp_obs());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_clk_en();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
